// File: rtl/axil_reg_arbiter.sv
// Two-requester round-robin front end that serialises single-beat register
// reads and writes onto one AXI4-Lite master port, one transaction at a time.
module axil_reg_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              resp,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_last_grant;
  logic                    r_gnt_idx;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_resp;
  logic [1:0]              r_ack;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_arvalid;
  logic                    r_bready;
  logic                    r_rready;

  logic                    w_grant_valid;
  logic                    w_grant_idx;
  logic                    w_sel_we;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_grant;

  assign w_aw_hs = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid & M_AXI_WREADY;
  assign w_ar_hs = r_arvalid & M_AXI_ARREADY;
  assign w_grant = (r_state == IDLE) & w_grant_valid;

  // On a tie the requester that did not win last time is chosen
  always_comb begin
    w_grant_valid = |req;
    if (req == 2'b11) begin
      w_grant_idx = ~r_last_grant;
    end else begin
      w_grant_idx = req[1];
    end
    if (w_grant_idx) begin
      w_sel_we    = we[1];
      w_sel_addr  = addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      w_sel_wdata = wdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      w_sel_we    = we[0];
      w_sel_addr  = addr[ADDR_WIDTH-1:0];
      w_sel_wdata = wdata[DATA_WIDTH-1:0];
    end
  end

  // Next-state logic; a cleared AW/W valid means that channel already handshook
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_next = w_sel_we ? WADDR : RADDR;
        end else begin
          w_state_next = IDLE;
        end
      end
      WADDR: begin
        if ((~r_awvalid | w_aw_hs) & (~r_wvalid | w_w_hs)) begin
          w_state_next = WRESP;
        end else begin
          w_state_next = WADDR;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          w_state_next = DONE;
        end else begin
          w_state_next = WRESP;
        end
      end
      RADDR: begin
        if (w_ar_hs) begin
          w_state_next = RDATA;
        end else begin
          w_state_next = RADDR;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RDATA;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture, AXI channel registers and requester-side results
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_last_grant <= 1'b1;
      r_gnt_idx    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_resp       <= 2'b00;
      r_ack        <= 2'b00;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt_idx    <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_addr       <= w_sel_addr & ADDR_MASK;
        r_wdata      <= w_sel_wdata;
        r_awvalid    <= w_sel_we;
        r_wvalid     <= w_sel_we;
        r_arvalid    <= ~w_sel_we;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
        if (w_ar_hs) r_arvalid <= 1'b0;
      end
      if ((r_state == WRESP) && M_AXI_BVALID) begin
        r_resp <= M_AXI_BRESP;
      end
      if ((r_state == RDATA) && M_AXI_RVALID) begin
        r_rdata <= M_AXI_RDATA;
        r_resp  <= M_AXI_RRESP;
      end
      r_bready <= (w_state_next == WRESP);
      r_rready <= (w_state_next == RDATA);
      r_ack    <= (w_state_next == DONE) ? (2'b01 << r_gnt_idx) : 2'b00;
    end
  end

  assign ack           = r_ack;
  assign rdata         = r_rdata;
  assign resp          = r_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Bench for axil_reg_arbiter: AXI4-Lite memory slave with programmable ready
// and response delays, a vector table, directed corner sequences and a random phase.
module tb_axil_reg_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          ACLK   = 1'b0;
  logic          ARESET = 1'b1;
  logic [1:0]    req    = 2'b00;
  logic [1:0]    we     = 2'b00;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic [1:0]    resp;
  logic [AW-1:0] M_AXI_AWADDR;
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY;
  logic [DW-1:0] M_AXI_WDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP;
  logic          M_AXI_BVALID;
  logic          M_AXI_BREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic          M_AXI_ARVALID;
  logic          M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RVALID;
  logic          M_AXI_RREADY;

  axil_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .resp(resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Slave configuration (written by the stimulus only)
  int       aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic     rerr_cfg = 1'b0;

  // Slave state and monitors
  logic [31:0] smem [0:3] = '{32'd0, 32'd0, 32'd0, 32'd0};
  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic        got_aw, got_w, r_pend;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  int          awv_cyc = 0, wv_cyc = 0, aw_hs_n = 0, b_hs_n = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
  assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_dly);
  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_cnt + 1  : 0;
      ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
      if (M_AXI_AWVALID) awv_cyc <= awv_cyc + 1;
      if (M_AXI_WVALID)  wv_cyc  <= wv_cyc + 1;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        got_aw <= 1'b1; s_awaddr <= M_AXI_AWADDR; last_awaddr <= M_AXI_AWADDR;
        aw_hs_n <= aw_hs_n + 1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        got_w <= 1'b1; s_wdata <= M_AXI_WDATA;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b0; b_hs_n <= b_hs_n + 1;
      end
      if ((got_aw || (M_AXI_AWVALID && M_AXI_AWREADY)) && (got_w || (M_AXI_WVALID && M_AXI_WREADY))) begin
        smem[(M_AXI_AWVALID && M_AXI_AWREADY) ? M_AXI_AWADDR[3:2] : s_awaddr[3:2]] <=
          (M_AXI_WVALID && M_AXI_WREADY) ? M_AXI_WDATA : s_wdata;
        M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= bresp_cfg;
        got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        last_araddr <= M_AXI_ARADDR;
        if (r_dly == 0) begin
          M_AXI_RVALID <= 1'b1;
          M_AXI_RDATA  <= smem[M_AXI_ARADDR[3:2]];
          M_AXI_RRESP  <= (rerr_cfg && M_AXI_ARADDR == 4'h8) ? 2'b10 : 2'b00;
        end else begin
          r_pend <= 1'b1; r_cnt <= r_dly - 1; s_araddr <= M_AXI_ARADDR;
        end
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          M_AXI_RVALID <= 1'b1;
          M_AXI_RDATA  <= smem[s_araddr[3:2]];
          M_AXI_RRESP  <= (rerr_cfg && s_araddr == 4'h8) ? 2'b10 : 2'b00;
          r_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mmem [0:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_resp"}, 32'(resp), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_valid_ready"}, 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    chk({tag, "_addr"}, 32'({M_AXI_AWADDR, M_AXI_ARADDR}), 32'd0);
  endtask

  task automatic apply_reset();
    ARESET = 1'b1; req = 2'b00;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(posedge ACLK); #1;
  endtask

  // One requester transaction; called and returns #1 after a rising edge
  task automatic run_txn(input int n, input bit wr, input logic [3:0] a, input logic [31:0] d,
                         output logic [1:0] o_ack, output logic [1:0] o_resp,
                         output logic [31:0] o_data, output int lat);
    req[n] = 1'b1; we[n] = wr; addr[n*AW +: AW] = a; wdata[n*DW +: DW] = d;
    lat = 0;
    do begin
      @(posedge ACLK); #1; lat++;
    end while (ack == 2'b00 && lat < 100);
    o_ack = ack; o_resp = resp; o_data = rdata;
    req[n] = 1'b0;
    @(posedge ACLK); #1;
  endtask

  typedef struct {
    int          rq;
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [1:0]  bresp;
    bit          rerr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_axaddr;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [1:0] g_ack, g_resp;
    logic [31:0] g_data;
    int lat, cnt, snap_awv, snap_wv, snap_b, snap_aw;
    logic [1:0] seq[$];
    bit active[2];
    bit op_we[2];
    logic [3:0] op_a[2];
    logic [31:0] op_d[2];
    int issued, done_n, rr_expect;

    for (int i = 0; i < 4; i++) mmem[i] = 32'd0;

    vecs.push_back('{0, 1'b1, 4'h0, 32'h1, 2'b00, 1'b0, 2'b00, 32'h0, 4'h0});
    vecs.push_back('{0, 1'b1, 4'h4, 32'h2, 2'b00, 1'b0, 2'b00, 32'h0, 4'h4});
    vecs.push_back('{0, 1'b1, 4'h8, 32'h3, 2'b00, 1'b0, 2'b00, 32'h0, 4'h8});
    vecs.push_back('{0, 1'b1, 4'hC, 32'h4, 2'b00, 1'b0, 2'b00, 32'h0, 4'hC});
    vecs.push_back('{0, 1'b0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h1, 4'h0});
    vecs.push_back('{0, 1'b0, 4'h4, 32'h0, 2'b00, 1'b0, 2'b00, 32'h2, 4'h4});
    vecs.push_back('{0, 1'b0, 4'h8, 32'h0, 2'b00, 1'b0, 2'b00, 32'h3, 4'h8});
    vecs.push_back('{0, 1'b0, 4'hC, 32'h0, 2'b00, 1'b0, 2'b00, 32'h4, 4'hC});
    vecs.push_back('{1, 1'b1, 4'h6, 32'hA5A5_0006, 2'b00, 1'b0, 2'b00, 32'h0, 4'h4});
    vecs.push_back('{1, 1'b0, 4'h7, 32'h0, 2'b00, 1'b0, 2'b00, 32'hA5A5_0006, 4'h4});
    vecs.push_back('{0, 1'b0, 4'h8, 32'h0, 2'b00, 1'b1, 2'b10, 32'h3, 4'h8});
    vecs.push_back('{1, 1'b1, 4'hC, 32'h44, 2'b11, 1'b0, 2'b11, 32'h0, 4'hC});
    vecs.push_back('{1, 1'b0, 4'hD, 32'h0, 2'b00, 1'b0, 2'b00, 32'h44, 4'hC});

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    check_reset_state("reset");
    chk("reset_wstrb", 32'(M_AXI_WSTRB), 32'hF);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Vector table, zero-wait slave
    foreach (vecs[i]) begin
      bresp_cfg = vecs[i].bresp; rerr_cfg = vecs[i].rerr;
      run_txn(vecs[i].rq, vecs[i].wr, vecs[i].a, vecs[i].d, g_ack, g_resp, g_data, lat);
      chk($sformatf("vec%0d_ack", i), 32'(g_ack), 32'(2'b01 << vecs[i].rq));
      chk($sformatf("vec%0d_resp", i), 32'(g_resp), 32'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_awaddr", i), 32'(last_awaddr), 32'(vecs[i].exp_axaddr));
        mmem[vecs[i].a[3:2]] = vecs[i].d;
      end else begin
        chk($sformatf("vec%0d_rdata", i), g_data, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_araddr", i), 32'(last_araddr), 32'(vecs[i].exp_axaddr));
      end
    end
    bresp_cfg = 2'b00; rerr_cfg = 1'b0;
    chk("rdata_hold", rdata, 32'h44);

    // AWREADY three cycles late, WREADY immediate
    aw_dly = 3;
    snap_awv = awv_cyc; snap_wv = wv_cyc; snap_b = b_hs_n;
    run_txn(0, 1'b1, 4'h8, 32'h0000_0033, g_ack, g_resp, g_data, lat);
    chk("awdelay_ack", 32'(g_ack), 32'd1);
    chk("awdelay_awvalid_cycles", 32'(awv_cyc - snap_awv), 32'd4);
    chk("awdelay_wvalid_cycles", 32'(wv_cyc - snap_wv), 32'd1);
    chk("awdelay_b_handshakes", 32'(b_hs_n - snap_b), 32'd1);
    mmem[2] = 32'h0000_0033;
    aw_dly = 0;

    // Reset while waiting in the read-data phase
    r_dly = 20;
    req[0] = 1'b1; we[0] = 1'b0; addr[3:0] = 4'h4;
    cnt = 0;
    while (M_AXI_RREADY !== 1'b1 && cnt < 20) begin
      @(posedge ACLK); #1; cnt++;
    end
    chk("midrst_reached_rdata", 32'(M_AXI_RREADY), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("midrst_rready_async", 32'(M_AXI_RREADY), 32'd0);
    chk("midrst_ack_async", 32'(ack), 32'd0);
    req = 2'b00; r_dly = 0;
    @(posedge ACLK); #1;
    check_reset_state("midrst");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    run_txn(0, 1'b0, 4'h4, 32'h0, g_ack, g_resp, g_data, lat);
    chk("postrst_ack", 32'(g_ack), 32'd1);
    chk("postrst_rdata", g_data, mmem[1]);
    chk("postrst_latency", 32'(lat), 32'd3);

    // Both requesters writing continuously after a fresh reset
    apply_reset();
    snap_aw = aw_hs_n; snap_b = b_hs_n;
    we = 2'b11; addr = {4'h4, 4'h0}; wdata = {32'h0000_BBBB, 32'h0000_AAAA};
    req = 2'b11;
    cnt = 0;
    while (seq.size() < 4 && cnt < 60) begin
      @(posedge ACLK); #1; cnt++;
      if (ack != 2'b00) begin
        seq.push_back(ack);
        if (seq.size() == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rr_ack_count", 32'(seq.size()), 32'd4);
    foreach (seq[i]) chk($sformatf("rr_grant%0d", i), 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    chk("rr_aw_handshakes", 32'(aw_hs_n - snap_aw), 32'd4);
    chk("rr_b_handshakes", 32'(b_hs_n - snap_b), 32'd4);
    mmem[0] = 32'h0000_AAAA; mmem[1] = 32'h0000_BBBB;

    // Random traffic from both requesters against the memory model
    active[0] = 1'b0; active[1] = 1'b0;
    issued = 0; done_n = 0; rr_expect = -1;
    for (int cyc = 0; cyc < 4000 && !(issued >= 60 && !active[0] && !active[1]); cyc++) begin
      logic [1:0] acked;
      acked = ack;
      if (acked != 2'b00) begin
        int n;
        n = acked[1] ? 1 : 0;
        chk("rand_ack_valid", 32'({active[n], (acked == 2'b01 || acked == 2'b10)}), 32'd3);
        if (rr_expect >= 0) chk("rand_round_robin", 32'(n), 32'(rr_expect));
        rr_expect = active[1-n] ? 1 - n : -1;
        chk("rand_resp", 32'(resp), 32'd0);
        if (op_we[n]) begin
          mmem[op_a[n][3:2]] = op_d[n];
        end else begin
          chk("rand_rdata", rdata, mmem[op_a[n][3:2]]);
        end
        active[n] = 1'b0; req[n] = 1'b0; done_n++;
        aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
        ar_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
      end
      for (int m = 0; m < 2; m++) begin
        if (!active[m] && !acked[m] && issued < 60 && $urandom_range(0, 3) == 0) begin
          active[m] = 1'b1; issued++;
          op_we[m] = 1'($urandom_range(0, 1));
          op_a[m]  = 4'($urandom_range(0, 15));
          op_d[m]  = $urandom;
          req[m] = 1'b1; we[m] = op_we[m];
          addr[m*AW +: AW] = op_a[m]; wdata[m*DW +: DW] = op_d[m];
        end
      end
      @(posedge ACLK); #1;
    end
    chk("rand_drained", 32'({active[1], active[0]}), 32'd0);
    chk("rand_completed", 32'(done_n), 32'(issued));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
